// File: rtl/fireball_scheduler.sv
// fireball_scheduler
//   Owns up to NUM_BALLS fireball slots (8x8 sprites on a 96x64 OLED): accepts
//   launch requests, advances every active ball by SPEED pixels once per frame
//   tick, and resolves which ball (if any) covers the pixel being scanned so the
//   single fireball sprite renderer can be shared.
//
//   Optional feature macro: FIREBALL_BOUNCE_EN
//     defined   - a ball reaching a screen edge bounces once (dir flips, x is
//                 clamped); the second edge hit removes it.
//     undefined - a ball reaching a screen edge is removed.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   frame_tick   in   one-cycle pulse per frame; starts a movement sweep
//   fire_req     in   launch request level, held until fire_ack
//   fire_x/y     in   launch leftX / topY (clamped to MAX_X / MAX_Y)
//   fire_dir     in   launch direction, 0 = right, 1 = left
//   fire_ack     out  one-cycle pulse, cycle after a launch is accepted
//   full         out  every slot active
//   active_mask  out  per-slot active flags
//   X / Y        in   OLED scan pixel column / row
//   ball_hit     out  registered: (X,Y) inside an active ball
//   leftX/topY   out  registered position of the lowest-index covering ball;
//                     hold their value when nothing is hit
//
// state | meaning
// IDLE  | waiting; starts a sweep on a tick, otherwise serves launch requests
// MOVE  | sweep: one slot advanced per cycle, slot 0 .. NUM_BALLS-1

module fireball_scheduler #(
    parameter int NUM_BALLS = 4,
    parameter int SPEED     = 2,
    parameter int SCREEN_W  = 96,
    parameter int MAX_X     = SCREEN_W - 8,
    parameter int MAX_Y     = 56
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 fire_req,
    input  logic [6:0]           fire_x,
    input  logic [5:0]           fire_y,
    input  logic                 fire_dir,
    output logic                 fire_ack,
    output logic                 full,
    output logic [NUM_BALLS-1:0] active_mask,
    input  logic [6:0]           X,
    input  logic [5:0]           Y,
    output logic                 ball_hit,
    output logic [6:0]           leftX,
    output logic [5:0]           topY
);

    localparam int IW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BALLS - 1);
    localparam logic [7:0] SPEED8 = 8'(SPEED);
    localparam logic [6:0] SPEED7 = 7'(SPEED);
    localparam logic [7:0] MAX_X8 = 8'(MAX_X);
    localparam logic [6:0] MAX_X7 = 7'(MAX_X);
    localparam logic [5:0] MAX_Y6 = 6'(MAX_Y);

    typedef enum logic [0:0] {IDLE, MOVE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                tick_pending_q;

    logic [NUM_BALLS-1:0] act_q;
    logic [NUM_BALLS-1:0] dir_q;
    logic [6:0]           x_q [NUM_BALLS];
    logic [5:0]           y_q [NUM_BALLS];
`ifdef FIREBALL_BOUNCE_EN
    logic [NUM_BALLS-1:0] bnc_q;
    logic                 cur_bnc, step_bnc;
`endif

    logic                 start_sweep, launch_go;
    logic                 free_found;
    logic [IW-1:0]        free_idx;
    logic [6:0]           cur_x, step_x;
    logic                 cur_dir, step_dir, step_act, at_edge;
    logic [7:0]           sum_r;
    logic                 hit_found;
    logic [6:0]           hit_x;
    logic [5:0]           hit_y;

    assign active_mask = act_q;
    assign full        = &act_q;
    assign start_sweep = frame_tick | tick_pending_q;
    // The requester still holds fire_req while fire_ack is high, so the ack
    // cycle must not be taken as a second request.
    assign launch_go   = (state_q == IDLE) && !start_sweep && fire_req
                         && free_found && !fire_ack;

    // lowest-index inactive slot
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start_sweep) begin
                    state_d = MOVE;
                    idx_d   = '0;
                end
            end
            MOVE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // movement step for the slot selected by the sweep index
    always_comb begin
        cur_x   = '0;
        cur_dir = 1'b0;
`ifdef FIREBALL_BOUNCE_EN
        cur_bnc = 1'b0;
`endif
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_x   = x_q[i];
                cur_dir = dir_q[i];
`ifdef FIREBALL_BOUNCE_EN
                cur_bnc = bnc_q[i];
`endif
            end
        end
        // 8-bit sum so a ball near the right edge cannot wrap back to the left
        sum_r    = {1'b0, cur_x} + SPEED8;
        at_edge  = cur_dir ? ({1'b0, cur_x} < SPEED8) : (sum_r > MAX_X8);
        step_x   = cur_dir ? (cur_x - SPEED7) : sum_r[6:0];
        step_dir = cur_dir;
        step_act = 1'b1;
`ifdef FIREBALL_BOUNCE_EN
        step_bnc = cur_bnc;
        if (at_edge) begin
            if (!cur_bnc) begin
                step_dir = ~cur_dir;
                step_bnc = 1'b1;
                step_x   = cur_dir ? 7'd0 : MAX_X7;
            end else begin
                step_act = 1'b0;
                step_x   = cur_x;
            end
        end
`else
        if (at_edge) begin
            step_act = 1'b0;
            step_x   = cur_x;
        end
`endif
    end

    // pixel query: scan high to low so the lowest hitting index wins
    always_comb begin
        hit_found = 1'b0;
        hit_x     = '0;
        hit_y     = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (act_q[i]
                && ({1'b0, X} >= {1'b0, x_q[i]})
                && ({1'b0, X} <= ({1'b0, x_q[i]} + 8'd7))
                && ({1'b0, Y} >= {1'b0, y_q[i]})
                && ({1'b0, Y} <= ({1'b0, y_q[i]} + 7'd7))) begin
                hit_found = 1'b1;
                hit_x     = x_q[i];
                hit_y     = y_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            tick_pending_q <= 1'b0;
            fire_ack       <= 1'b0;
            act_q          <= '0;
            dir_q          <= '0;
`ifdef FIREBALL_BOUNCE_EN
            bnc_q          <= '0;
`endif
            for (int i = 0; i < NUM_BALLS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            ball_hit       <= 1'b0;
            leftX          <= '0;
            topY           <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fire_ack <= launch_go;

            // one-deep tick memory; extra ticks while pending are dropped
            if (state_q == MOVE) begin
                if (frame_tick) tick_pending_q <= 1'b1;
            end else if (start_sweep) begin
                tick_pending_q <= 1'b0;
            end

            for (int i = 0; i < NUM_BALLS; i++) begin
                if (launch_go && (free_idx == IW'(i))) begin
                    act_q[i] <= 1'b1;
                    dir_q[i] <= fire_dir;
                    x_q[i]   <= (fire_x > MAX_X7) ? MAX_X7 : fire_x;
                    y_q[i]   <= (fire_y > MAX_Y6) ? MAX_Y6 : fire_y;
`ifdef FIREBALL_BOUNCE_EN
                    bnc_q[i] <= 1'b0;
`endif
                end else if ((state_q == MOVE) && (idx_q == IW'(i)) && act_q[i]) begin
                    act_q[i] <= step_act;
                    dir_q[i] <= step_dir;
                    x_q[i]   <= step_x;
`ifdef FIREBALL_BOUNCE_EN
                    bnc_q[i] <= step_bnc;
`endif
                end
            end

            ball_hit <= hit_found;
            if (hit_found) begin
                leftX <= hit_x;
                topY  <= hit_y;
            end
        end
    end

endmodule

// File: tb/tb_fireball_scheduler.sv
module tb_fireball_scheduler;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic          fire_req = 1'b0;
    logic [6:0]    fire_x = '0;
    logic [5:0]    fire_y = '0;
    logic          fire_dir = 1'b0;
    logic          fire_ack;
    logic          full;
    logic [NB-1:0] active_mask;
    logic [6:0]    X = '0;
    logic [5:0]    Y = '0;
    logic          ball_hit;
    logic [6:0]    leftX;
    logic [5:0]    topY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       hit;
        logic [6:0] lx;
        logic [5:0] ty;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    bit   q_issue = 1'b0;
    bit   q_armed = 1'b0;

    always #5 clk = ~clk;

    fireball_scheduler #(.NUM_BALLS(NB), .SPEED(2)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .fire_req(fire_req), .fire_x(fire_x), .fire_y(fire_y), .fire_dir(fire_dir),
        .fire_ack(fire_ack), .full(full), .active_mask(active_mask),
        .X(X), .Y(Y), .ball_hit(ball_hit), .leftX(leftX), .topY(topY)
    );

    // query scoreboard: expectation queued with the pixel, checked one clock later
    always @(negedge clk) begin
        if (q_armed) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL query_sb: result due but nothing queued");
            end else begin
                mon_e = sbq.pop_front();
                if ({ball_hit, leftX, topY} !== {mon_e.hit, mon_e.lx, mon_e.ty}) begin
                    errors++;
                    $display("FAIL query: got hit=%0b leftX=%0d topY=%0d, expected hit=%0b leftX=%0d topY=%0d",
                             ball_hit, leftX, topY, mon_e.hit, mon_e.lx, mon_e.ty);
                end
            end
        end
        q_armed = q_issue;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic query(input logic [6:0] qx, input logic [5:0] qy,
                         input logic eh, input logic [6:0] el, input logic [5:0] et);
        exp_t e;
        X = qx;
        Y = qy;
        e.hit = eh;
        e.lx  = el;
        e.ty  = et;
        sbq.push_back(e);
        q_issue = 1'b1;
        cyc();
        q_issue = 1'b0;
    endtask

    // returns cycles until fire_ack, or -1 if none within 20 cycles
    task automatic do_launch(input logic [6:0] lx, input logic [5:0] ly,
                             input logic ld, output int lat);
        fire_x   = lx;
        fire_y   = ly;
        fire_dir = ld;
        fire_req = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (fire_ack) begin
                lat = c;
                break;
            end
        end
        fire_req = 1'b0;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        fire_req   = 1'b0;
        frame_tick = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        fire_req = 1'b1;
        fire_x   = 7'd5;
        X        = 7'd5;
        reset    = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({fire_ack, full, active_mask, ball_hit, leftX, topY} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%0b full=%0b mask=%b hit=%0b leftX=%0d topY=%0d, all must be 0",
                     fire_ack, full, active_mask, ball_hit, leftX, topY);
        end
        fire_req = 1'b0;
        reset    = 1'b0;
        cyc();
        checks++;
        if (active_mask !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle_mask: got %b expected 0000", active_mask);
        end
    endtask

    task automatic test_launch();
        int lat;
        int extra;
        apply_reset();
        do_launch(7'd10, 6'd20, 1'b0, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL launch_ack_latency: got %0d expected 1", lat);
        end
        extra = 0;
        repeat (4) begin
            cyc();
            if (fire_ack) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL launch_ack_single: got %0d extra ack cycles expected 0", extra);
        end
        checks++;
        if (active_mask !== 4'b0001) begin
            errors++;
            $display("FAIL launch_mask: got %b expected 0001", active_mask);
        end
        query(7'd12, 6'd25, 1'b1, 7'd10, 6'd20);
        do_launch(7'd120, 6'd63, 1'b1, lat);
        checks++;
        if (active_mask !== 4'b0011) begin
            errors++;
            $display("FAIL launch_clamp_mask: got %b expected 0011", active_mask);
        end
        query(7'd95, 6'd63, 1'b1, 7'd88, 6'd56);
    endtask

    task automatic test_right_edge();
        int lat;
        apply_reset();
        do_launch(7'd86, 6'd40, 1'b0, lat);
        do_tick();
        checks++;
        if (active_mask !== 4'b0001) begin
            errors++;
            $display("FAIL edge_first_tick_mask: got %b expected 0001", active_mask);
        end
        query(7'd95, 6'd47, 1'b1, 7'd88, 6'd40);
        do_tick();
`ifdef FIREBALL_BOUNCE_EN
        checks++;
        if (active_mask !== 4'b0001) begin
            errors++;
            $display("FAIL edge_bounce_mask: got %b expected 0001", active_mask);
        end
        query(7'd95, 6'd47, 1'b1, 7'd88, 6'd40);
        do_tick();
        query(7'd93, 6'd47, 1'b1, 7'd86, 6'd40);
`else
        checks++;
        if (active_mask !== 4'b0000) begin
            errors++;
            $display("FAIL edge_exit_mask: got %b expected 0000", active_mask);
        end
        query(7'd90, 6'd42, 1'b0, 7'd88, 6'd40);
`endif
    endtask

    task automatic test_full();
        int lat;
        int acks;
        int ticks;
        apply_reset();
        do_launch(7'd80, 6'd0, 1'b1, lat);
        do_launch(7'd80, 6'd16, 1'b1, lat);
        do_launch(7'd1, 6'd32, 1'b1, lat);
        do_launch(7'd80, 6'd48, 1'b1, lat);
        cyc();
        checks++;
        if ({full, active_mask} !== 5'b1_1111) begin
            errors++;
            $display("FAIL full_after_four: full=%0b mask=%b expected full=1 mask=1111", full, active_mask);
        end
        fire_x   = 7'd30;
        fire_y   = 6'd30;
        fire_dir = 1'b0;
        fire_req = 1'b1;
        acks = 0;
        repeat (10) begin
            cyc();
            if (fire_ack) acks++;
        end
        fire_req = 1'b0;
        checks++;
        if (acks != 0 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_no_ack: acks=%0d full=%0b expected acks=0 full=1", acks, full);
        end
        ticks = 0;
`ifdef FIREBALL_BOUNCE_EN
        while (active_mask[2] && ticks < 60) begin
            do_tick();
            ticks++;
        end
`else
        do_tick();
        ticks = 1;
        checks++;
        if (active_mask !== 4'b1011) begin
            errors++;
            $display("FAIL full_left_exit_mask: got %b expected 1011", active_mask);
        end
`endif
        checks++;
        if (active_mask[2] !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL full_slot2_exit: mask=%b full=%0b after %0d ticks, expected slot 2 clear", active_mask, full, ticks);
        end
        do_launch(7'd30, 6'd30, 1'b0, lat);
        checks++;
        if (lat < 1 || active_mask !== 4'b1111) begin
            errors++;
            $display("FAIL full_refill: lat=%0d mask=%b expected ack and mask 1111", lat, active_mask);
        end
        query(7'd33, 6'd35, 1'b1, 7'd30, 6'd30);
    endtask

    task automatic test_tick_priority();
        int lat;
        int early;
        apply_reset();
        do_launch(7'd20, 6'd8, 1'b0, lat);
        cyc();
        fire_x     = 7'd40;
        fire_y     = 6'd40;
        fire_dir   = 1'b0;
        fire_req   = 1'b1;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        early = fire_ack ? 1 : 0;
        repeat (4) begin
            cyc();
            if (fire_ack) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL prio_no_ack_in_move: got %0d ack cycles expected 0", early);
        end
        lat = -1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (fire_ack) begin
                lat = c;
                break;
            end
        end
        fire_req = 1'b0;
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL prio_ack_after_sweep: got latency %0d expected 1", lat);
        end
        query(7'd43, 6'd44, 1'b1, 7'd40, 6'd40);
        query(7'd29, 6'd8, 1'b1, 7'd22, 6'd8);
    endtask

    task automatic test_overlap();
        int lat;
        apply_reset();
        do_launch(7'd40, 6'd10, 1'b0, lat);
        do_launch(7'd44, 6'd12, 1'b0, lat);
        query(7'd45, 6'd13, 1'b1, 7'd40, 6'd10);
        query(7'd50, 6'd18, 1'b1, 7'd44, 6'd12);
        query(7'd0, 6'd63, 1'b0, 7'd44, 6'd12);
    endtask

    task automatic test_pending_tick();
        int lat;
        apply_reset();
        do_launch(7'd10, 6'd30, 1'b0, lat);
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (12) cyc();
        query(7'd21, 6'd30, 1'b1, 7'd14, 6'd30);
    endtask

    task automatic test_reset_mid_move();
        int lat;
        apply_reset();
        do_launch(7'd50, 6'd20, 1'b0, lat);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (active_mask !== 4'b0000) begin
            errors++;
            $display("FAIL midmove_reset_mask: got %b expected 0000", active_mask);
        end
        query(7'd51, 6'd21, 1'b0, 7'd0, 6'd0);
        do_launch(7'd50, 6'd20, 1'b0, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL midmove_relaunch: got latency %0d expected 1", lat);
        end
        do_tick();
        query(7'd59, 6'd27, 1'b1, 7'd52, 6'd20);
    endtask

    initial begin
        test_reset();
        test_launch();
        test_right_edge();
        test_full();
        test_tick_priority();
        test_overlap();
        test_pending_tick();
        test_reset_mid_move();
        repeat (3) cyc();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL query_sb_drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
